rc4_key_schedule: RTL

- Upstream stage of the RC4 decrypt pipeline: builds the 256-byte S working memory from a 24-bit secret key.
- Two phases: the initialisation fill s[i]=i, then the key-scheduling swap loop.
- When done it raises done; top level uses done to hand S-memory port ownership and start to the decrypt/keystream stage.
- Sole owner of the S-memory port (address/data/wren) while busy; the port mux sits outside this block.

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/key_byte_sel.sv | 36 +++
 rtl/rc4_key_schedule.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-schedule and decrypt stages.
// Both stages agree on the S-memory geometry and key length through this package.
package rc4_pkg;

   localparam int S_SIZE    = 256;
   localparam int KEY_BYTES = 3;

   typedef logic [7:0] byte_t;

   typedef enum logic [3:0] {
      IDLE,
      FILL,
      RD_I,
      WT_I,
      RD_J,
      WT_J,
      WR_I,
      WR_J,
      DONE
   } state_t;

endpackage

// File: rtl/key_byte_sel.sv
// Cycles an index through the latched key bytes (wraps at KEY_BYTES) and
// presents the currently selected byte; byte 0 is the most significant.
module key_byte_sel #(
   parameter int KEY_BYTES = rc4_pkg::KEY_BYTES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   advance,
   input  logic [8*KEY_BYTES-1:0] key,
   output logic [7:0]             key_byte
);
   import rc4_pkg::*;

   localparam int IW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   logic [IW-1:0] kidx_reg;
   byte_t         key_bytes [KEY_BYTES];

   for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_split
      assign key_bytes[gi] = key[8*(KEY_BYTES-gi)-1 -: 8];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kidx_reg <= '0;
      end else if (clear) begin
         kidx_reg <= '0;
      end else if (advance) begin
         kidx_reg <= (kidx_reg == IW'(KEY_BYTES-1)) ? '0 : kidx_reg + 1'b1;
      end
   end

   assign key_byte = key_bytes[kidx_reg];

endmodule

// File: rtl/rc4_key_schedule.sv
// RC4 key-scheduling stage: fills S with the identity permutation, then runs the
// KSA swap loop through a single-port S-memory with registered address.
module rc4_key_schedule #(
   parameter int KEY_BYTES = rc4_pkg::KEY_BYTES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [7:0]             s_q,
   output logic [7:0]             s_add,
   output logic [7:0]             s_data,
   output logic                   wrenS,
   output logic                   busy,
   output logic                   done
);
   import rc4_pkg::*;

   localparam byte_t LAST = byte_t'(S_SIZE-1);

   state_t                 state_reg, state_next;
   byte_t                  i_reg, j_reg, si_reg, sj_reg;
   logic [8*KEY_BYTES-1:0] key_reg;
   byte_t                  key_byte;
   logic                   launch;
   logic                   kidx_advance;

   assign launch       = ((state_reg == IDLE) || (state_reg == DONE)) && start;
   assign kidx_advance = (state_reg == WR_J) && (i_reg != LAST);

   key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_byte_sel (
      .clk      (clk),
      .reset    (reset),
      .clear    (launch),
      .advance  (kidx_advance),
      .key      (key_reg),
      .key_byte (key_byte)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         i_reg     <= '0;
         j_reg     <= '0;
         si_reg    <= '0;
         sj_reg    <= '0;
         key_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  key_reg <= secret_key;
                  i_reg   <= '0;
                  j_reg   <= '0;
               end
            end
            FILL: i_reg <= (i_reg == LAST) ? '0 : i_reg + 8'd1;
            // Read data for address i is on s_q during WT_I.
            WT_I: begin
               si_reg <= s_q;
               j_reg  <= j_reg + s_q + key_byte;
            end
            WT_J: sj_reg <= s_q;
            WR_J: if (i_reg != LAST) i_reg <= i_reg + 8'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      s_add      = '0;
      s_data     = '0;
      wrenS      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = FILL;
         end
         FILL: begin
            s_add  = i_reg;
            s_data = i_reg;
            wrenS  = 1'b1;
            if (i_reg == LAST) state_next = RD_I;
         end
         RD_I: begin
            s_add      = i_reg;
            state_next = WT_I;
         end
         WT_I: begin
            s_add      = i_reg;
            state_next = RD_J;
         end
         RD_J: begin
            s_add      = j_reg;
            state_next = WT_J;
         end
         WT_J: begin
            s_add      = j_reg;
            state_next = WR_I;
         end
         WR_I: begin
            s_add      = i_reg;
            s_data     = sj_reg;
            wrenS      = 1'b1;
            state_next = WR_J;
         end
         WR_J: begin
            s_add      = j_reg;
            s_data     = si_reg;
            wrenS      = 1'b1;
            state_next = (i_reg == LAST) ? DONE : RD_I;
         end
         DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (start) state_next = FILL;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

endmodule
